// File: rtl/aes_key_pkg.sv
// AES-128 key-schedule constants, state encoding and word helpers.
// EQ_INV_KEY_EN adds the InvMixColumns transform used for equivalent-inverse-cipher keys.
package aes_key_pkg;

  localparam int unsigned AES_ROUNDS = 10;

  // Entries 0 and 11..15 are padding so a 4-bit round index always lands in range.
  localparam logic [7:0] RCON_TBL [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {IDLE, EXPAND, READY, SERVE} state_e;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] xor_chain(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

`ifdef EQ_INV_KEY_EN
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] k);
    return {inv_mix_col(k[127:96]), inv_mix_col(k[95:64]),
            inv_mix_col(k[63:32]), inv_mix_col(k[31:0])};
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, single byte, purely combinational lookup.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  always_comb begin
    base     = {in_byte, 3'b000};
    out_byte = SBOX_TBL[11'd2047 - base -: 8];
  end

endmodule

// File: rtl/key_step_core.sv
// One AES-128 key-schedule step, forward (dir=0) or inverse (dir=1), through one shared SubWord.
module key_step_core
  import aes_key_pkg::*;
(
  input  logic         dir,
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] sel_w, rot_w, sub_w, t_w;

  // Inverse direction rebuilds the previous w3 (w3 ^ w2) before SubWord.
  assign sel_w = dir ? (key_in[31:0] ^ key_in[63:32]) : key_in[31:0];
  assign rot_w = rot_word(sel_w);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*g +: 8]),
      .out_byte (sub_w[8*g +: 8])
    );
  end

  assign t_w = sub_w ^ {rcon, 24'h0};

  always_comb begin
    key_out = xor_chain(key_in, t_w);
    if (dir) begin
      key_out = {key_in[127:96] ^ t_w,
                 key_in[127:96] ^ key_in[95:64],
                 key_in[95:64]  ^ key_in[63:32],
                 key_in[63:32]  ^ key_in[31:0]};
    end
  end

endmodule

// File: rtl/inv_round_key_gen.sv
// Decryption key schedule: expands once to round 10 (chg_key -> change_key_done in 11 cycles), then
// serves keys 10..0, one per dec_step, each visible the next cycle. Build option EQ_INV_KEY_EN.
module inv_round_key_gen
  import aes_key_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES_ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         chg_key,
  input  logic [127:0] rx_key,
  input  logic         dec_start,
  input  logic         dec_step,
  output logic [127:0] dec_key,
  output logic [3:0]   dec_round,
  output logic         key_valid,
  output logic         expand_busy,
  output logic         change_key_done
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [127:0] last_q, last_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   dec_round_q, dec_round_d;
  logic         done_q, done_d;
  logic         step_inv;
  logic [7:0]   step_rcon;
  logic [127:0] step_key;

  assign step_inv  = (state_q == SERVE);
  assign step_rcon = RCON_TBL[step_inv ? dec_round_q : cnt_q];

  key_step_core u_step (
    .dir     (step_inv),
    .key_in  (key_q),
    .rcon    (step_rcon),
    .key_out (step_key)
  );

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    dec_round_d = dec_round_q;
    done_d      = 1'b0;
    if (chg_key) begin
      key_d   = rx_key;
      cnt_d   = 4'd1;
      state_d = EXPAND;
    end else begin
      case (state_q)
        EXPAND: begin
          key_d = step_key;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_RND) begin
            last_d  = step_key;
            done_d  = 1'b1;
            cnt_d   = 4'd0;
            state_d = READY;
          end
        end
        READY, SERVE: begin
          if (dec_start) begin
            key_d       = last_q;
            dec_round_d = LAST_RND;
            state_d     = SERVE;
          end else if (dec_step && state_q == SERVE) begin
            // Stepping past round 0 ends the walk; the round-0 key stays in key_q.
            if (dec_round_q != 4'd0) begin
              key_d       = step_key;
              dec_round_d = dec_round_q - 4'd1;
            end else begin
              state_d = READY;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      dec_round_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      dec_round_q <= dec_round_d;
      done_q      <= done_d;
    end
  end

  assign key_valid       = (state_q == SERVE);
  assign expand_busy     = (state_q == EXPAND);
  assign change_key_done = done_q;
  assign dec_round       = dec_round_q;

`ifdef EQ_INV_KEY_EN
  assign dec_key = (dec_round_q != 4'd0 && dec_round_q != LAST_RND) ? inv_mix_columns(key_q) : key_q;
`else
  assign dec_key = key_q;
`endif

endmodule

// File: tb/tb_inv_round_key_gen.sv
// Bench for inv_round_key_gen: known-answer table plus randomized keys against a software key schedule.
module tb_inv_round_key_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         chg_key = 1'b0;
  logic [127:0] rx_key = '0;
  logic         dec_start = 1'b0;
  logic         dec_step = 1'b0;
  logic [127:0] dec_key;
  logic [3:0]   dec_round;
  logic         key_valid;
  logic         expand_busy;
  logic         change_key_done;

  inv_round_key_gen dut (
    .clk             (clk),
    .rst             (rst),
    .chg_key         (chg_key),
    .rx_key          (rx_key),
    .dec_start       (dec_start),
    .dec_step        (dec_step),
    .dec_key         (dec_key),
    .dec_round       (dec_round),
    .key_valid       (key_valid),
    .expand_busy     (expand_busy),
    .change_key_done (change_key_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] r10;
    logic [127:0] r9;
    logic [127:0] r1;
  } vec_t;

  vec_t         vecs [2];
  logic [7:0]   sbox_tab [256];
  logic [127:0] rk [11];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_tab[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                    {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Standard 44-word forward expansion; rk[r] is the round-r key.
  task automatic make_sched(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (96 - 32 * i));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

`ifdef EQ_INV_KEY_EN
  localparam logic [7:0] IMC_ROW [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0]   b [16];
    logic [127:0] o;
    logic [7:0]   acc;
    for (int i = 0; i < 16; i++) b[i] = 8'(s >> (120 - 8 * i));
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gm(IMC_ROW[(k - r + 4) % 4], b[4*c+k]);
        o = {o[119:0], acc};
      end
    return o;
  endfunction
`endif

  function automatic logic [127:0] exp_out(input logic [127:0] raw, input int r);
`ifdef EQ_INV_KEY_EN
    if (r >= 1 && r <= 9) return inv_mix(raw);
`endif
    return raw;
  endfunction

  task automatic load_key(input logic [127:0] k, input bit poke, input bit with_start);
    int lat;
    rx_key    = k;
    chg_key   = 1'b1;
    dec_start = with_start;
    tick();
    chg_key   = 1'b0;
    dec_start = 1'b0;
    lat = 1;
    chk("load_busy", 128'(expand_busy), 128'(1));
    chk("load_valid", 128'(key_valid), 128'(0));
    while (change_key_done !== 1'b1 && lat < 40) begin
      dec_start = poke && lat == 3;
      dec_step  = poke && lat == 3;
      tick();
      dec_start = 1'b0;
      dec_step  = 1'b0;
      lat++;
      if (change_key_done !== 1'b1) chk("expand_valid", 128'(key_valid), 128'(0));
    end
    chk("expand_latency", 128'(lat), 128'(11));
    chk("done_busy_fell", 128'(expand_busy), 128'(0));
    chk("ready_valid", 128'(key_valid), 128'(0));
    tick();
    chk("done_pulse", 128'(change_key_done), 128'(0));
  endtask

  task automatic walk(input bit gaps, input bit use_tab, input vec_t v);
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0;
    chk("start_valid", 128'(key_valid), 128'(1));
    chk("start_round", 128'(dec_round), 128'(10));
    chk("key_r10_model", dec_key, exp_out(rk[10], 10));
    if (use_tab) chk("key_r10_table", dec_key, v.r10);
    for (int r = 9; r >= 0; r--) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          tick();
          chk("hold_round", 128'(dec_round), 128'(r + 1));
        end
      end
      dec_step = 1'b1;
      tick();
      dec_step = 1'b0;
      chk("step_round", 128'(dec_round), 128'(r));
      chk("step_key_model", dec_key, exp_out(rk[r], r));
      if (use_tab) begin
        if (r == 9) chk("key_r9_table", dec_key, exp_out(v.r9, 9));
        if (r == 1) chk("key_r1_table", dec_key, exp_out(v.r1, 1));
        if (r == 0) chk("key_r0_table", dec_key, v.key);
      end
    end
    dec_step = 1'b1;
    tick();
    dec_step = 1'b0;
    chk("past_r0_valid", 128'(key_valid), 128'(0));
  endtask

  initial begin
    vecs[0].key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    vecs[0].r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    vecs[0].r9  = 128'hac7766f319fadc2128d12941575c006e;
    vecs[0].r1  = 128'ha0fafe1788542cb123a339392a6c7605;
    vecs[1].key = 128'h000102030405060708090a0b0c0d0e0f;
    vecs[1].r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    vecs[1].r9  = 128'h549932d1f08557681093ed9cbe2c974e;
    vecs[1].r1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    build_sbox();

    tick();
    tick();
    chk("rst_key", dec_key, 128'(0));
    chk("rst_round", 128'(dec_round), 128'(0));
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_busy", 128'(expand_busy), 128'(0));
    chk("rst_done", 128'(change_key_done), 128'(0));
    rst = 1'b0;

    dec_start = 1'b1;
    dec_step  = 1'b1;
    tick();
    dec_start = 1'b0;
    dec_step  = 1'b0;
    chk("idle_ignore_valid", 128'(key_valid), 128'(0));

    for (int i = 0; i < 2; i++) begin
      make_sched(vecs[i].key);
      load_key(vecs[i].key, i == 1, 1'b0);
      walk(1'b0, 1'b1, vecs[i]);
      dec_step = 1'b1;
      tick();
      dec_step = 1'b0;
      chk("ready_step_ignored", 128'(key_valid), 128'(0));
      dec_start = 1'b1;
      tick();
      dec_start = 1'b0;
      chk("restart_round", 128'(dec_round), 128'(10));
      chk("restart_key", dec_key, vecs[i].r10);
    end

    repeat (2) begin
      dec_step = 1'b1;
      tick();
    end
    chk("pre_both_round", 128'(dec_round), 128'(8));
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0;
    dec_step  = 1'b0;
    chk("start_wins_round", 128'(dec_round), 128'(10));
    chk("start_wins_key", dec_key, exp_out(rk[10], 10));

    for (int n = 0; n < 6; n++) begin
      logic [127:0] k;
      int           m;
      k = {$urandom, $urandom, $urandom, $urandom};
      m = $urandom_range(0, 9);
      dec_start = 1'b1;
      tick();
      dec_start = 1'b0;
      for (int s = 0; s < m; s++) begin
        dec_step = 1'b1;
        tick();
        dec_step = 1'b0;
        chk("pre_chg_key", dec_key, exp_out(rk[9-s], 9 - s));
      end
      make_sched(k);
      load_key(k, 1'b0, n[0]);
      walk(1'b1, 1'b0, vecs[0]);
    end

    rx_key  = {$urandom, $urandom, $urandom, $urandom};
    chg_key = 1'b1;
    tick();
    chg_key = 1'b0;
    repeat (4) tick();
    chk("mid_expand_busy", 128'(expand_busy), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_key", dec_key, 128'(0));
    chk("rst2_round", 128'(dec_round), 128'(0));
    chk("rst2_valid", 128'(key_valid), 128'(0));
    chk("rst2_busy", 128'(expand_busy), 128'(0));
    chk("rst2_done", 128'(change_key_done), 128'(0));
    dec_start = 1'b1;
    tick();
    dec_start = 1'b0;
    chk("idle_ignore2_valid", 128'(key_valid), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
